// File: rtl/dma_out_arbiter_if.sv
// -----------------------------------------------------------------------------
// dma_out_arbiter_if
// Handshake bundle between the per-channel DSP result buffers, the block-output
// DMA engine and the round-robin arbiter that shares that engine.
//
// Parameters:
//   NUM_REQ        number of requesting buffers
// Signals:
//   req            level request per buffer, held until that buffer's ack
//   dma_done       one-cycle completion pulse from the DMA engine
//   start_dma_out  one-cycle start pulse to the DMA engine
//   grant          one-hot current owner, zero when idle
//   grant_idx      binary owner index (buffer mux select)
//   ack            one-cycle pulse to the owner when its transfer ends
//   busy           high from grant until release completes
//   timeout_flag   sticky watchdog error
// Modports:
//   master         arbiter side (drives the DMA/mux controls)
//   slave          buffers + DMA side
// -----------------------------------------------------------------------------
interface dma_out_arbiter_if #(
    parameter int NUM_REQ = 4
);
    localparam int IDX_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0] req;
    logic               dma_done;
    logic               start_dma_out;
    logic [NUM_REQ-1:0] grant;
    logic [IDX_W-1:0]   grant_idx;
    logic [NUM_REQ-1:0] ack;
    logic               busy;
    logic               timeout_flag;

    modport master (
        input  req, dma_done,
        output start_dma_out, grant, grant_idx, ack, busy, timeout_flag
    );

    modport slave (
        output req, dma_done,
        input  start_dma_out, grant, grant_idx, ack, busy, timeout_flag
    );
endinterface

// File: rtl/dma_out_arbiter.sv
// -----------------------------------------------------------------------------
// dma_out_arbiter
// Round-robin scheduler sharing one block-output DMA engine among NUM_REQ
// result buffers. Picks a requester, pulses start_dma_out for one cycle, holds
// grant/grant_idx through the transfer, waits for dma_done, acks the owner for
// one cycle and re-arbitrates. All outputs are registered.
//
// Parameters:
//   NUM_REQ         number of requesters (>= 2)
//   TIMEOUT_CYCLES  WAIT_DONE watchdog limit (only with DMA_ARB_TIMEOUT_EN)
// Ports:
//   clk             clock
//   reset           asynchronous, active-high reset
//   bus             dma_out_arbiter_if.master (req/dma_done in, controls out)
// Build option:
//   DMA_ARB_TIMEOUT_EN  enables the WAIT_DONE watchdog and timeout_flag;
//                       when undefined WAIT_DONE waits forever and
//                       timeout_flag is tied low.
// -----------------------------------------------------------------------------
module dma_out_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  reset,
    dma_out_arbiter_if.master     bus
);
    localparam int IDX_W = $clog2(NUM_REQ);

    if (NUM_REQ < 2 || TIMEOUT_CYCLES < 1) begin : g_bad_param
        $error("dma_out_arbiter: NUM_REQ must be >= 2 and TIMEOUT_CYCLES >= 1");
    end

    typedef enum logic [1:0] {IDLE, START, WAIT_DONE, RELEASE} state_t;

    state_t             state_q, state_d;
    logic               start_q, start_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [NUM_REQ-1:0] ack_q, ack_d;
    logic               busy_q, busy_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;       // index of the last granted requester
    logic               expire;             // watchdog fires on this edge

    // Round-robin pick: scan from ptr+1 upward with wrap; first set bit wins.
    logic               win_found;
    logic [IDX_W-1:0]   win_idx;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        win_found = 1'b0;
        win_idx   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            int cand;
            cand = (int'(ptr_q) + k) % NUM_REQ;
            if (!win_found && bus.req[cand]) begin
                win_found = 1'b1;
                win_idx   = IDX_W'(cand);
            end
        end
    end

`ifdef DMA_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q;
    logic             flag_q;

    // cnt_q holds the number of completed WAIT_DONE cycles; the edge ending
    // the TIMEOUT_CYCLES-th one expires the transfer.
    assign expire = (state_q == WAIT_DONE) && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q  <= '0;
            flag_q <= 1'b0;
        end else begin
            if (state_q == START)
                cnt_q <= '0;
            else if (state_q == WAIT_DONE)
                cnt_q <= cnt_q + CNT_W'(1);
            // A done arriving on the expiry edge counts as a normal completion.
            if (expire && !bus.dma_done)
                flag_q <= 1'b1;
        end
    end

    assign bus.timeout_flag = flag_q;
`else
    assign expire           = 1'b0;
    assign bus.timeout_flag = 1'b0;
`endif

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of statement order.
            state_q <= IDLE;
            start_q <= 1'b0;
            grant_q <= '0;
            idx_q   <= '0;
            ack_q   <= '0;
            busy_q  <= 1'b0;
            ptr_q   <= IDX_W'(NUM_REQ - 1);   // req[0] has top priority after reset
        end else begin
            state_q <= state_d;
            start_q <= start_d;
            grant_q <= grant_d;
            idx_q   <= idx_d;
            ack_q   <= ack_d;
            busy_q  <= busy_d;
            ptr_q   <= ptr_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (win_found) state_d = START;
            START:     state_d = WAIT_DONE;
            WAIT_DONE: if (bus.dma_done || expire) state_d = RELEASE;
            RELEASE:   state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    // Next values of the registered outputs.
    always_comb begin
        start_d = 1'b0;
        ack_d   = '0;
        grant_d = grant_q;
        idx_d   = idx_q;
        busy_d  = busy_q;
        ptr_d   = ptr_q;
        case (state_q)
            IDLE: begin
                if (win_found) begin
                    grant_d = NUM_REQ'(1) << win_idx;
                    idx_d   = win_idx;
                    busy_d  = 1'b1;
                    start_d = 1'b1;
                end
            end
            WAIT_DONE: begin
                if (bus.dma_done || expire) begin
                    ack_d = grant_q;
                    ptr_d = idx_q;
                end
            end
            RELEASE: begin
                grant_d = '0;
                idx_d   = '0;
                busy_d  = 1'b0;
            end
            default: ;
        endcase
    end

    assign bus.start_dma_out = start_q;
    assign bus.grant         = grant_q;
    assign bus.grant_idx     = idx_q;
    assign bus.ack           = ack_q;
    assign bus.busy          = busy_q;

endmodule

// File: tb/tb_dma_out_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dma_out_arbiter
// Directed bench for dma_out_arbiter (NUM_REQ=4, TIMEOUT_CYCLES=16). Inputs are
// driven and outputs sampled on the falling edge; the DUT acts on rising edges.
// The watchdog section follows DMA_ARB_TIMEOUT_EN.
// -----------------------------------------------------------------------------
module tb_dma_out_arbiter;
    logic clk   = 1'b0;
    logic reset = 1'b1;

    int n_assert = 0;
    int n_fail   = 0;

    dma_out_arbiter_if #(.NUM_REQ(4)) bus ();

    dma_out_arbiter #(.NUM_REQ(4), .TIMEOUT_CYCLES(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_start"}, 32'(bus.start_dma_out), 0);
        check({tag, "_grant"}, 32'(bus.grant), 0);
        check({tag, "_idx"},   32'(bus.grant_idx), 0);
        check({tag, "_ack"},   32'(bus.ack), 0);
        check({tag, "_busy"},  32'(bus.busy), 0);
        check({tag, "_flag"},  32'(bus.timeout_flag), 0);
    endtask

    // IDLE edge with req pending, then the START edge.
    task automatic grant_phase(input int exp);
        tick();
        check("start_pulse", 32'(bus.start_dma_out), 1);
        check("grant",       32'(bus.grant), 32'(1) << exp);
        check("grant_idx",   32'(bus.grant_idx), 32'(exp));
        check("busy_on",     32'(bus.busy), 1);
        tick();
        check("start_low",   32'(bus.start_dma_out), 0);
        check("idx_hold",    32'(bus.grant_idx), 32'(exp));
    endtask

    // wait_n further WAIT_DONE cycles, done pulse, release.
    task automatic done_phase(input int exp, input int wait_n, input logic drop);
        repeat (wait_n) tick();
        check("no_early_ack", 32'(bus.ack), 0);
        bus.dma_done = 1'b1;
        tick();
        bus.dma_done = 1'b0;
        check("ack",          32'(bus.ack), 32'(1) << exp);
        check("rel_idx_hold", 32'(bus.grant_idx), 32'(exp));
        check("rel_busy",     32'(bus.busy), 1);
        if (drop) bus.req[exp] = 1'b0;
        tick();
        check("ack_off",      32'(bus.ack), 0);
        check("grant_off",    32'(bus.grant), 0);
        check("busy_off",     32'(bus.busy), 0);
        check("idx_off",      32'(bus.grant_idx), 0);
    endtask

    initial begin
        int ack_seen;
        bus.req      = '0;
        bus.dma_done = 1'b0;

        // Reset state
        @(negedge clk);
        check_all_zero("reset");
        reset = 1'b0;

        // Single requester, done 10 cycles after start
        bus.req = 4'b0001;
        grant_phase(0);
        done_phase(0, 8, 1'b1);

        // Fresh pointer, all four requesting: order 0,1,2,3, then req[0] again
        reset = 1'b1;
        tick();
        reset = 1'b0;
        bus.req = 4'b1111;
        grant_phase(0); done_phase(0, 2, 1'b1);
        grant_phase(1); done_phase(1, 2, 1'b1);
        grant_phase(2); done_phase(2, 2, 1'b1);
        grant_phase(3); done_phase(3, 2, 1'b1);
        bus.req = 4'b0001;
        grant_phase(0); done_phase(0, 1, 1'b1);

        // 1010 with pointer at 0: grant 1; req[1] kept high competes lowest -> 3
        bus.req = 4'b1010;
        grant_phase(1); done_phase(1, 1, 1'b0);
        grant_phase(3);
        bus.req[2] = 1'b1;               // late request during WAIT_DONE
        tick();
        check("idx_stable_wait", 32'(bus.grant_idx), 3);
        check("grant_stable",    32'(bus.grant), 32'b1000);
        done_phase(3, 2, 1'b1);
        // req = 0110, pointer 3 -> 1 wins
        grant_phase(1); done_phase(1, 1, 1'b1);

        // req = 0100 -> grant 2, reset mid-WAIT_DONE
        grant_phase(2);
        tick();
        check("pre_reset_grant", 32'(bus.grant), 32'b0100);
        reset = 1'b1;
        #1;
        check_all_zero("async_reset");
        bus.req = 4'b0101;
        tick();
        check("reset_no_ack", 32'(bus.ack), 0);
        reset = 1'b0;
        grant_phase(0);
        bus.req = 4'b0001;
        done_phase(0, 2, 1'b1);

        // dma_done in IDLE is ignored
        bus.dma_done = 1'b1;
        tick();
        bus.dma_done = 1'b0;
        check("idle_done_ack",   32'(bus.ack), 0);
        check("idle_done_busy",  32'(bus.busy), 0);
        check("idle_done_start", 32'(bus.start_dma_out), 0);

        // dma_done in START is ignored
        bus.req = 4'b0010;
        tick();
        check("s_start", 32'(bus.start_dma_out), 1);
        check("s_idx",   32'(bus.grant_idx), 1);
        bus.dma_done = 1'b1;
        tick();
        bus.dma_done = 1'b0;
        check("start_done_ack",  32'(bus.ack), 0);
        check("start_done_busy", 32'(bus.busy), 1);
        tick();
        check("start_done_still_busy", 32'(bus.busy), 1);
        done_phase(1, 2, 1'b1);

`ifdef DMA_ARB_TIMEOUT_EN
        // Done on the 16th WAIT_DONE cycle: normal completion, flag clear
        bus.req = 4'b0001;
        grant_phase(0);
        done_phase(0, 15, 1'b1);
        check("flag_clear_on_edge_done", 32'(bus.timeout_flag), 0);

        // No done: ack after 16 WAIT_DONE cycles, sticky flag
        bus.req = 4'b0001;
        grant_phase(0);
        repeat (15) tick();
        check("to_no_ack_yet", 32'(bus.ack), 0);
        check("to_flag_low",   32'(bus.timeout_flag), 0);
        tick();
        check("to_ack",  32'(bus.ack), 32'b0001);
        check("to_flag", 32'(bus.timeout_flag), 1);
        bus.req = 4'b0000;
        tick();
        check("to_busy_off", 32'(bus.busy), 0);
        bus.req = 4'b0010;
        grant_phase(1);
        check("flag_sticky_grant", 32'(bus.timeout_flag), 1);
        done_phase(1, 2, 1'b1);
        check("flag_sticky_after", 32'(bus.timeout_flag), 1);
`else
        // No watchdog: still waiting after 1000 cycles
        bus.req = 4'b0001;
        grant_phase(0);
        ack_seen = 0;
        for (int i = 0; i < 1000; i++) begin
            tick();
            if (bus.ack != 4'b0000) ack_seen++;
        end
        check("no_timeout_ack",  32'(ack_seen), 0);
        check("no_timeout_busy", 32'(bus.busy), 1);
        check("no_timeout_flag", 32'(bus.timeout_flag), 0);
        done_phase(0, 0, 1'b1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
